sprite_anim_renderer: RTL

- Parametrised successor of the single-sprite ROM/palette demo renderer.
- Places a WxH multi-frame sprite at a runtime screen position, with integer power-of-two scaling and horizontal mirroring (one ROM serves left and right facing).
- Advances animation frames automatically on vertical-sync ticks.
- Drives an external synchronous sprite ROM and emits a palette index plus an opaque/inside flag, pipelined and aligned for the colour mapper.

---
 rtl/sprite_anim_renderer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sprite_anim_renderer.sv
// Renders one scaled, mirrorable, multi-frame animated sprite. A 3-stage pipeline
// turns DrawX/DrawY into a ROM address and then into a palette index with a coverage flag.
module sprite_anim_renderer #(
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 32,
    parameter int FRAMES      = 4,
    parameter int ADDR_W      = 12,
    parameter int INDEX_W     = 3,
    parameter int TRANSP_IDX  = 0,
    parameter int FRAME_TICKS = 8,
    localparam int FRAME_W    = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic               blank,
    input  logic               vs,
    input  logic [9:0]         SpriteX,
    input  logic [9:0]         SpriteY,
    input  logic [1:0]         scale_log2,
    input  logic               mirror,
    input  logic               anim_en,
    input  logic               anim_restart,
    output logic [ADDR_W-1:0]  rom_address,
    input  logic [INDEX_W-1:0] rom_q,
    output logic [INDEX_W-1:0] pix_index,
    output logic               pix_on,
    output logic [FRAME_W-1:0] cur_frame
);
    localparam int COL_W    = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int ROW_W    = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int TICK_W   = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int FRAME_SZ = SPR_W * SPR_H;

    logic [ADDR_W-1:0]  rom_address_reg, rom_address_next;
    logic               inside1_reg, inside1_next;
    logic               inside2_reg;
    logic [INDEX_W-1:0] pix_index_reg, pix_index_next;
    logic               pix_on_reg, pix_on_next;
    logic [FRAME_W-1:0] frame_reg, frame_next;
    logic [TICK_W-1:0]  tick_cnt_reg, tick_cnt_next;
    logic               vs_prev_reg;
    logic               tick;

    logic [10:0]        dx, dy;
    logic [11:0]        span_w, span_h;
    logic [COL_W-1:0]   col_raw, col;
    logic [ROW_W-1:0]   row;

    // Bit 10 of the 11-bit difference is the borrow, i.e. DrawX < SpriteX.
    assign dx     = {1'b0, DrawX} - {1'b0, SpriteX};
    assign dy     = {1'b0, DrawY} - {1'b0, SpriteY};
    assign span_w = 12'(SPR_W) << scale_log2;
    assign span_h = 12'(SPR_H) << scale_log2;

    assign inside1_next = blank & ~dx[10] & ~dy[10]
                        & ({1'b0, dx} < span_w) & ({1'b0, dy} < span_h);

    assign col_raw = COL_W'(dx[9:0] >> scale_log2);
    assign row     = ROW_W'(dy[9:0] >> scale_log2);

    // SPR_W is a power of two, so SPR_W-1-col is just the bitwise complement.
    genvar gi;
    generate
        for (gi = 0; gi < COL_W; gi++) begin : g_mirror
            assign col[gi] = col_raw[gi] ^ mirror;
        end
    endgenerate

    assign rom_address_next = inside1_next
        ? ADDR_W'(frame_reg) * ADDR_W'(FRAME_SZ) + ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(col)
        : '0;

    assign pix_on_next    = inside2_reg & (rom_q != INDEX_W'(TRANSP_IDX));
    assign pix_index_next = pix_on_next ? rom_q : '0;

    assign tick = vs_prev_reg & ~vs;

    always_comb begin
        tick_cnt_next = tick_cnt_reg;
        frame_next    = frame_reg;
        if (anim_restart) begin
            tick_cnt_next = '0;
            frame_next    = '0;
        end else if (anim_en && tick) begin
            if (tick_cnt_reg == TICK_W'(FRAME_TICKS - 1)) begin
                tick_cnt_next = '0;
                frame_next    = (frame_reg == FRAME_W'(FRAMES - 1)) ? '0 : frame_reg + FRAME_W'(1);
            end else begin
                tick_cnt_next = tick_cnt_reg + TICK_W'(1);
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_address_reg <= '0;
            inside1_reg     <= 1'b0;
            inside2_reg     <= 1'b0;
            pix_index_reg   <= '0;
            pix_on_reg      <= 1'b0;
        end else begin
            rom_address_reg <= rom_address_next;
            inside1_reg     <= inside1_next;
            inside2_reg     <= inside1_reg;
            pix_index_reg   <= pix_index_next;
            pix_on_reg      <= pix_on_next;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_reg    <= '0;
            tick_cnt_reg <= '0;
            vs_prev_reg  <= 1'b1;
        end else begin
            frame_reg    <= frame_next;
            tick_cnt_reg <= tick_cnt_next;
            vs_prev_reg  <= vs;
        end
    end

    assign rom_address = rom_address_reg;
    assign pix_index   = pix_index_reg;
    assign pix_on      = pix_on_reg;
    assign cur_frame   = frame_reg;

endmodule
